syzygy_adc_capture: RTL and testbench

Captures dual-channel ADC samples into a Block RAM port so Zynq PS software can read the waveform back. It is the write side of the BRAM path: the DAC DDS path reads BRAM that the PS fills, and this block fills BRAM that the PS reads. It sits between the ADC PHY (samples already deserialized to `clk`) and the `BRAM_PORTB` interface of the block design. Control and status connect to AXI GPIO registers.

---
 rtl/syzygy_adc_pkg.sv | 39 +++
 rtl/syzygy_adc_if.sv | 10 +
 rtl/syzygy_adc_trig.sv | 36 +++
 rtl/syzygy_adc_capture.sv | 159 +++++++++++++++
 tb/tb_syzygy_adc_capture.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/syzygy_adc_pkg.sv
// Shared types and helpers for the ADC-to-BRAM capture path.
// Holds the capture FSM states, trigger mode codes and BRAM word packing.
package syzygy_adc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   localparam logic TRIG_IMMEDIATE = 1'b0;
   localparam logic TRIG_LEVEL     = 1'b1;

   // Sign-extends the low w bits of each channel to 16 bits, channel B in the upper half.
   function automatic logic [31:0] pack_word(input logic [15:0] a, input logic [15:0] b,
                                             input int w);
      logic [15:0] ea;
      logic [15:0] eb;
      logic        sa;
      logic        sb;
      sa = 1'b0;
      sb = 1'b0;
      ea = '0;
      eb = '0;
      for (int i = 0; i < 16; i++) begin
         if (i == w - 1) begin
            sa = a[i];
            sb = b[i];
         end
      end
      for (int i = 0; i < 16; i++) begin
         ea[i] = (i < w) ? a[i] : sa;
         eb[i] = (i < w) ? b[i] : sb;
      end
      return {eb, ea};
   endfunction

endpackage

// File: rtl/syzygy_adc_if.sv
// Block RAM write port (BRAM_PORTB side) driven by the capture block.
interface syzygy_adc_if;
   logic [31:0] bram_addr;
   logic [31:0] bram_din;
   logic [3:0]  bram_we;
   logic        bram_en;

   modport master (output bram_addr, output bram_din, output bram_we, output bram_en);
   modport slave  (input bram_addr, input bram_din, input bram_we, input bram_en);
endinterface

// File: rtl/syzygy_adc_trig.sv
// Rising level-crossing detector on channel A; trig_o is high for the one valid
// sample that crosses from below the level to at-or-above it.
module syzygy_adc_trig #(
   parameter int ADC_W = 14
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clr_i,
   input  logic                    en_i,
   input  logic                    valid_i,
   input  logic signed [ADC_W-1:0] a_i,
   input  logic signed [ADC_W-1:0] level_i,
   output logic                    trig_o
);

   logic signed [ADC_W-1:0] prev_q;
   logic                    prev_vld_q;

   // A fresh arm forgets the previous sample so a stale value cannot fake a crossing.
   always_ff @(posedge clk) begin
      if (reset || clr_i) begin
         prev_vld_q <= 1'b0;
      end else if (valid_i) begin
         prev_vld_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (valid_i) begin
         prev_q <= a_i;
      end
   end

   assign trig_o = en_i && valid_i && prev_vld_q && (prev_q < level_i) && (a_i >= level_i);

endmodule

// File: rtl/syzygy_adc_capture.sv
// Captures decimated dual-channel ADC samples into BRAM for PS readback, with
// immediate or level-crossing trigger, abort, and AXI-GPIO style status.
module syzygy_adc_capture
   import syzygy_adc_pkg::*;
#(
   parameter int DEPTH = 4096,
   parameter int ADC_W = 14
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [ADC_W-1:0] adc_a,
   input  logic signed [ADC_W-1:0] adc_b,
   input  logic                    adc_valid,
   input  logic                    arm,
   input  logic                    abort,
   input  logic                    trig_mode,
   input  logic signed [ADC_W-1:0] trig_level,
   input  logic [15:0]             capture_len,
   input  logic [15:0]             decim,
   syzygy_adc_if.master            bram,
   output logic                    busy,
   output logic                    done,
   output logic [15:0]             words_written
);

   localparam int LEN_W = $clog2(DEPTH) + 1;

   state_e                  state_q, state_d;
   logic                    mode_q, mode_d;
   logic signed [ADC_W-1:0] level_q, level_d;
   logic [15:0]             decim_q, decim_d;
   logic [LEN_W-1:0]        len_q, len_d;
   logic [LEN_W-1:0]        words_q, words_d;
   logic [15:0]             dcnt_q, dcnt_d;
   logic [LEN_W-1:0]        len_in;
   logic                    store;
   logic                    arm_acc;
   logic                    trig;

   logic [31:0]             addr_q;
   logic [31:0]             din_q;
   logic [3:0]              we_q;
   logic                    en_q;
   logic                    busy_q;
   logic                    done_q;

   assign len_in = (32'(capture_len) > DEPTH) ? LEN_W'(DEPTH) : LEN_W'(capture_len);

   syzygy_adc_trig #(.ADC_W(ADC_W)) u_trig (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (arm_acc),
      .en_i    ((state_q == ST_ARMED) && (mode_q == TRIG_LEVEL)),
      .valid_i (adc_valid),
      .a_i     (adc_a),
      .level_i (level_q),
      .trig_o  (trig)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      level_d = level_q;
      decim_d = decim_q;
      len_d   = len_q;
      words_d = words_q;
      dcnt_d  = dcnt_q;
      store   = 1'b0;
      arm_acc = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (arm) begin
               if (abort) begin
                  state_d = ST_IDLE;
               end else begin
                  arm_acc = 1'b1;
                  mode_d  = trig_mode;
                  level_d = trig_level;
                  decim_d = decim;
                  len_d   = len_in;
                  words_d = '0;
                  state_d = (len_in == '0) ? ST_DONE : ST_ARMED;
               end
            end
         end
         ST_ARMED: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (mode_q == TRIG_IMMEDIATE) begin
               state_d = ST_CAPTURE;
               dcnt_d  = '0;
            end else if (trig) begin
               // The crossing sample itself is the first one kept (decimation phase 0).
               store   = 1'b1;
               state_d = ST_CAPTURE;
               dcnt_d  = (decim_q == '0) ? '0 : 16'd1;
            end
         end
         ST_CAPTURE: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (adc_valid) begin
               store  = (dcnt_q == '0);
               dcnt_d = (dcnt_q == decim_q) ? '0 : dcnt_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (store) begin
         words_d = words_q + LEN_W'(1);
         if (words_d == len_q) begin
            state_d = ST_DONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         mode_q  <= TRIG_IMMEDIATE;
         level_q <= '0;
         decim_q <= '0;
         len_q   <= '0;
         words_q <= '0;
         dcnt_q  <= '0;
         addr_q  <= '0;
         din_q   <= '0;
         we_q    <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         level_q <= level_d;
         decim_q <= decim_d;
         len_q   <= len_d;
         words_q <= words_d;
         dcnt_q  <= dcnt_d;
         we_q    <= store ? 4'hF : 4'h0;
         en_q    <= store;
         if (store) begin
            addr_q <= 32'({words_q, 2'b00});
            din_q  <= pack_word(16'(adc_a), 16'(adc_b), ADC_W);
         end
         busy_q  <= (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
         done_q  <= (state_d == ST_DONE);
      end
   end

   assign bram.bram_addr = addr_q;
   assign bram.bram_din  = din_q;
   assign bram.bram_we   = we_q;
   assign bram.bram_en   = en_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign words_written  = 16'(words_q);

endmodule

// File: tb/tb_syzygy_adc_capture.sv
// Self-checking bench for syzygy_adc_capture: table-driven immediate captures plus
// hand-written level, abort, reset and re-arm sequences, all scored against a write queue.
module tb_syzygy_adc_capture;

   logic               clk;
   logic               reset;
   logic signed [13:0] adc_a;
   logic signed [13:0] adc_b;
   logic               adc_valid;
   logic               arm;
   logic               abort;
   logic               trig_mode;
   logic signed [13:0] trig_level;
   logic [15:0]        capture_len;
   logic [15:0]        decim;
   logic               busy;
   logic               done;
   logic [15:0]        words_written;

   syzygy_adc_if bram_bus();

   syzygy_adc_capture #(.DEPTH(4096), .ADC_W(14)) dut (
      .clk           (clk),
      .reset         (reset),
      .adc_a         (adc_a),
      .adc_b         (adc_b),
      .adc_valid     (adc_valid),
      .arm           (arm),
      .abort         (abort),
      .trig_mode     (trig_mode),
      .trig_level    (trig_level),
      .capture_len   (capture_len),
      .decim         (decim),
      .bram          (bram_bus),
      .busy          (busy),
      .done          (done),
      .words_written (words_written)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] din;
   } wr_t;

   typedef struct {
      logic [15:0] len;
      logic [15:0] dec;
      int          gap;
      int          exp_words;
      logic [31:0] exp_last;
   } row_t;

   wr_t  exp_q[$];
   int   checks;
   int   failures;
   int   cyc;
   int   nwr;
   int   wr_cyc [0:8191];
   logic [31:0] last_addr;
   bit   chk_done;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h required=%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int a_of(input int idx);
      return idx - 2000;
   endfunction

   function automatic int b_of(input int idx);
      return 1500 - 3 * (idx % 1000);
   endfunction

   function automatic logic [31:0] word_of(input int a, input int b);
      logic [15:0] a16;
      logic [15:0] b16;
      a16 = 16'(a);
      b16 = 16'(b);
      return {b16, a16};
   endfunction

   task automatic drive(input int idx);
      adc_a = 14'(a_of(idx));
      adc_b = 14'(b_of(idx));
   endtask

   task automatic push(input int k, input logic [31:0] din);
      wr_t e;
      e.addr = 32'(k * 4);
      e.din  = din;
      exp_q.push_back(e);
   endtask

   // Write monitor / scoreboard, sampled on the falling edge.
   initial begin
      wr_t e;
      nwr = 0;
      last_addr = '0;
      forever begin
         @(negedge clk);
         chk("en_vs_we", 32'(bram_bus.bram_en), 32'(|bram_bus.bram_we));
         if (bram_bus.bram_en === 1'b1) begin
            chk("we_on_write", 32'(bram_bus.bram_we), 32'hF);
            wr_cyc[nwr % 8192] = cyc;
            nwr++;
            last_addr = bram_bus.bram_addr;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write got=addr %0h din %0h required=no write",
                        bram_bus.bram_addr, bram_bus.bram_din);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", bram_bus.bram_addr, e.addr);
               chk("wr_din", bram_bus.bram_din, e.din);
               chk("words_at_write", 32'(words_written), (e.addr >> 2) + 32'd1);
               if (chk_done) chk("done_at_write", 32'(done), 32'(exp_q.size() == 0));
            end
         end
      end
   end

   initial begin
      row_t rows[6];
      int   mark;
      int   k;
      int   idx;
      int   nv;
      int   trig_cyc;

      rows[0] = '{16'd8,     16'd0, 0, 8,    32'h1C};
      rows[1] = '{16'd3,     16'd2, 1, 3,    32'h08};
      rows[2] = '{16'd0,     16'd0, 0, 0,    32'h00};
      rows[3] = '{16'd5,     16'd1, 0, 5,    32'h10};
      rows[4] = '{16'd1,     16'd3, 2, 1,    32'h00};
      rows[5] = '{16'd65535, 16'd0, 0, 4096, 32'h3FFC};

      checks = 0;
      failures = 0;
      chk_done = 1'b1;
      reset = 1'b1;
      adc_a = '0;
      adc_b = '0;
      adc_valid = 1'b0;
      arm = 1'b0;
      abort = 1'b0;
      trig_mode = 1'b0;
      trig_level = '0;
      capture_len = '0;
      decim = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("rst_addr", bram_bus.bram_addr, 32'd0);
      chk("rst_din", bram_bus.bram_din, 32'd0);
      chk("rst_we", 32'(bram_bus.bram_we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_words", 32'(words_written), 32'd0);

      // Immediate-mode captures; config inputs are scrambled after arm to prove latching.
      for (int r = 0; r < 6; r++) begin
         mark = nwr;
         chk_done = 1'b1;
         capture_len = rows[r].len;
         decim = rows[r].dec;
         trig_mode = 1'b0;
         arm = 1'b1;
         adc_valid = 1'b0;
         tick();
         arm = 1'b0;
         capture_len = 16'd1;
         decim = 16'd7;
         chk("row_busy_after_arm", 32'(busy), 32'(rows[r].exp_words != 0));
         chk("row_done_after_arm", 32'(done), 32'(rows[r].exp_words == 0));
         chk("row_words_after_arm", 32'(words_written), 32'd0);
         tick();
         k = 0;
         for (int i = 0; k < rows[r].exp_words; i += int'(rows[r].dec) + 1) begin
            push(k, word_of(a_of(i), b_of(i)));
            k++;
         end
         nv = (rows[r].exp_words == 0) ? 2 :
              (rows[r].exp_words - 1) * (int'(rows[r].dec) + 1) + 4;
         idx = 0;
         for (int c = 0; idx < nv; c++) begin
            if (c % (rows[r].gap + 1) == 0) begin
               adc_valid = 1'b1;
               drive(idx);
               idx++;
            end else begin
               adc_valid = 1'b0;
            end
            tick();
         end
         adc_valid = 1'b0;
         tick();
         tick();
         chk("row_words", 32'(words_written), 32'(rows[r].exp_words));
         chk("row_done", 32'(done), 32'd1);
         chk("row_busy", 32'(busy), 32'd0);
         chk("row_nwrites", 32'(nwr - mark), 32'(rows[r].exp_words));
         chk("row_pending", 32'(exp_q.size()), 32'd0);
         if (rows[r].exp_words != 0) chk("row_last_addr", last_addr, rows[r].exp_last);
      end

      // Level trigger on a -50..200 ramp: first stored sample is 100, written next cycle.
      mark = nwr;
      trig_mode = 1'b1;
      trig_level = 14'sd100;
      capture_len = 16'd4;
      decim = 16'd0;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      trig_mode = 1'b0;
      trig_level = -14'sd500;
      for (int j = 0; j < 4; j++) push(j, word_of(100 + 10 * j, -(100 + 10 * j)));
      trig_cyc = -1;
      for (int v = -50; v <= 200; v += 10) begin
         adc_valid = 1'b1;
         adc_a = 14'(v);
         adc_b = 14'(-v);
         tick();
         if (v == 100) trig_cyc = cyc;
      end
      adc_valid = 1'b0;
      tick();
      chk("lvl_nwrites", 32'(nwr - mark), 32'd4);
      chk("lvl_pending", 32'(exp_q.size()), 32'd0);
      chk("lvl_first_wr_cycle", 32'(wr_cyc[mark % 8192]), 32'(trig_cyc));
      chk("lvl_done", 32'(done), 32'd1);
      chk("lvl_words", 32'(words_written), 32'd4);

      // A held above level right after arm must not trigger (previous sample invalid).
      mark = nwr;
      adc_valid = 1'b1;
      adc_a = 14'sd50;
      tick();
      trig_mode = 1'b1;
      trig_level = 14'sd100;
      capture_len = 16'd4;
      arm = 1'b1;
      adc_a = 14'sd150;
      tick();
      arm = 1'b0;
      repeat (20) tick();
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_words", 32'(words_written), 32'd0);
      chk("hold_nwrites", 32'(nwr - mark), 32'd0);
      abort = 1'b1;
      adc_valid = 1'b0;
      tick();
      abort = 1'b0;
      chk("hold_abort_busy", 32'(busy), 32'd0);
      chk("hold_abort_done", 32'(done), 32'd0);

      // Abort after 5 of 10 words.
      mark = nwr;
      chk_done = 1'b0;
      trig_mode = 1'b0;
      capture_len = 16'd10;
      decim = 16'd0;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) push(i, word_of(a_of(i), b_of(i)));
      adc_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(i);
         tick();
      end
      abort = 1'b1;
      drive(5);
      tick();
      abort = 1'b0;
      for (int i = 6; i < 16; i++) begin
         drive(i);
         tick();
      end
      adc_valid = 1'b0;
      tick();
      chk("abort_words", 32'(words_written), 32'd5);
      chk("abort_nwrites", 32'(nwr - mark), 32'd5);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_pending", 32'(exp_q.size()), 32'd0);

      // Reset mid-capture: outputs return to reset values the next cycle.
      mark = nwr;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) push(i, word_of(a_of(i), b_of(i)));
      adc_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(i);
         tick();
      end
      reset = 1'b1;
      drive(3);
      tick();
      reset = 1'b0;
      chk("mid_rst_addr", bram_bus.bram_addr, 32'd0);
      chk("mid_rst_din", bram_bus.bram_din, 32'd0);
      chk("mid_rst_we", 32'(bram_bus.bram_we), 32'd0);
      chk("mid_rst_en", 32'(bram_bus.bram_en), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_words", 32'(words_written), 32'd0);
      for (int i = 4; i < 9; i++) begin
         drive(i);
         tick();
      end
      adc_valid = 1'b0;
      tick();
      chk("mid_rst_nwrites", 32'(nwr - mark), 32'd3);
      chk("mid_rst_pending", 32'(exp_q.size()), 32'd0);

      // arm and abort together: stays idle.
      mark = nwr;
      capture_len = 16'd4;
      arm = 1'b1;
      abort = 1'b1;
      tick();
      arm = 1'b0;
      abort = 1'b0;
      chk("armabort_busy", 32'(busy), 32'd0);
      adc_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(i);
         tick();
      end
      adc_valid = 1'b0;
      chk("armabort_busy_later", 32'(busy), 32'd0);
      chk("armabort_done", 32'(done), 32'd0);
      chk("armabort_nwrites", 32'(nwr - mark), 32'd0);

      // arm while busy is ignored: the capture runs on with its original settings.
      mark = nwr;
      chk_done = 1'b1;
      trig_mode = 1'b0;
      capture_len = 16'd6;
      decim = 16'd0;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      tick();
      for (int i = 0; i < 6; i++) push(i, word_of(a_of(i), b_of(i)));
      adc_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         drive(i);
         if (i == 2) begin
            arm = 1'b1;
            capture_len = 16'd2;
            decim = 16'd5;
         end else begin
            arm = 1'b0;
         end
         tick();
      end
      arm = 1'b0;
      adc_valid = 1'b0;
      tick();
      chk("busyarm_words", 32'(words_written), 32'd6);
      chk("busyarm_done", 32'(done), 32'd1);
      chk("busyarm_last_addr", last_addr, 32'h14);
      chk("busyarm_nwrites", 32'(nwr - mark), 32'd6);
      chk("busyarm_pending", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
